// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between the VGA
// scan-out reader and a PPU pixel writer. Reads in the picture window always
// win; PPU writes are queued in a FIFO and drained whenever the scan-out is
// outside the window (horizontal blank, right border, vertical blank).
//
// Ports:
//   Clk, Reset              single clock, synchronous active-high reset
//   DrawX, DrawY, blank     VGA timing generator coordinates / visible flag
//   wr_valid/wr_addr/
//   wr_data/wr_ready        PPU write channel, addr = {y[7:0], x[7:0]}
//   ram_addr/ram_we/
//   ram_wdata/ram_rdata     framebuffer RAM port (read data one cycle late)
//   pix_data                palette index to the colour mapper
//   vblank_pulse            one-cycle strobe at start of vertical blank
//   fifo_overrun            sticky: a write was offered while the FIFO was full
module vga_fb_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter logic [5:0]  BORDER_COLOR = 6'h0F
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [10:0] DrawX,
    input  logic [10:0] DrawY,
    input  logic        blank,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [5:0]  wr_data,
    output logic        wr_ready,
    output logic [15:0] ram_addr,
    output logic        ram_we,
    output logic [5:0]  ram_wdata,
    input  logic [5:0]  ram_rdata,
    output logic [5:0]  pix_data,
    output logic        vblank_pulse,
    output logic        fifo_overrun
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 6;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0] Y_VISIBLE = 11'd480;

    typedef enum logic {
        ST_ACTIVE  = 1'b0,
        ST_VBLANK  = 1'b1
    } state_t;

    // Storage and registered state
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wr_ready_q;
    logic               overrun_q;
    logic [1:0]         win_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [ADDR_W-1:0]  last_addr_q;
    logic [DATA_W-1:0]  last_wdata_q;
    state_t             state_q, state_d;
    logic               pulse_q, pulse_d;

    // Combinational control
    logic               read_win;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [ADDR_W-1:0]  read_addr;

    // DrawX is always even, so its LSB carries no information.
    logic unused_drawx_lsb;
    assign unused_drawx_lsb = DrawX[0];

    // Window evaluation, FIFO handshake and RAM port mux.
    always_comb begin
        read_win   = blank && (DrawX[10:1] < 10'd256) && (DrawY < Y_VISIBLE);
        fifo_empty = (count_q == '0);
        wr_ready   = wr_ready_q && !Reset;
        push       = wr_valid && wr_ready;
        // Reset gating here aborts the write that would otherwise issue this cycle.
        pop        = !Reset && !read_win && !fifo_empty;
        head       = mem[rd_ptr_q];
        read_addr  = {DrawY[8:1], DrawX[8:1]};
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        ram_we    = pop;
        ram_addr  = last_addr_q;
        ram_wdata = last_wdata_q;
        if (Reset) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end else if (read_win) begin
            ram_addr  = read_addr;
        end else if (pop) begin
            ram_addr  = head[ENTRY_W-1:DATA_W];
            ram_wdata = head[DATA_W-1:0];
        end

        pix_data     = (!Reset && win_q[1]) ? rdata_q : BORDER_COLOR;
        vblank_pulse = pulse_q && !Reset;
        fifo_overrun = overrun_q && !Reset;
    end

    // Frame FSM: strobe only on the ACTIVE -> VBLANK edge.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (DrawY >= Y_VISIBLE) begin
                    state_d = ST_VBLANK;
                    pulse_d = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (DrawY < Y_VISIBLE) begin
                    state_d = ST_ACTIVE;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // Control and pipeline registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_ACTIVE;
            pulse_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_ready_q   <= 1'b1;
            overrun_q    <= 1'b0;
            win_q        <= '0;
            rdata_q      <= '0;
            last_addr_q  <= '0;
            last_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pulse_q      <= pulse_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            wr_ready_q   <= (count_d != CNT_FULL);
            overrun_q    <= overrun_q || (wr_valid && !wr_ready);
            win_q        <= {win_q[0], read_win};
            rdata_q      <= ram_rdata;
            last_addr_q  <= ram_addr;
            last_wdata_q <= ram_wdata;
        end
    end

    // FIFO storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {wr_addr, wr_data};
        end
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 16, giving the write-FIFO entries (power of two).
REQ-002 The block SHALL have parameter BORDER_COLOR, default 6'h0F, giving the palette index driven outside the picture window.
REQ-003 The block SHALL have port Clk  input  1  the single clock for all logic, the same clock as the VGA timing generator.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port DrawX  input  11  horizontal coordinate from the VGA timing generator, which is always even.
REQ-006 The block SHALL have port DrawY  input  11  vertical coordinate from the VGA timing generator.
REQ-007 The block SHALL have port blank  input  1  visible-pixel flag, where 1 means visible.
REQ-008 The block SHALL have port wr_valid  input  1  the PPU offers one pixel write.
REQ-009 The block SHALL have port wr_addr  input  16  the PPU write address {y[7:0], x[7:0]}.
REQ-010 The block SHALL have port wr_data  input  6  the PPU palette index.
REQ-011 The block SHALL have port wr_ready  output  1  the write is accepted this cycle when wr_valid is also 1.
REQ-012 The block SHALL have port ram_addr  output  16  single-port framebuffer address.
REQ-013 The block SHALL have port ram_we  output  1  framebuffer write enable.
REQ-014 The block SHALL have port ram_wdata  output  6  framebuffer write data.
REQ-015 The block SHALL have port ram_rdata  input  6  framebuffer read data, valid one cycle after the address.
REQ-016 The block SHALL have port pix_data  output  6  palette index for the VGA colour mapper.
REQ-017 The block SHALL have port vblank_pulse  output  1  one-cycle start-of-vblank strobe, used as the NMI source.
REQ-018 The block SHALL have port fifo_overrun  output  1  sticky flag meaning a write was offered while the FIFO was full.

Function
REQ-019 The read window SHALL be the condition blank=1 AND DrawX[10:1]<256 AND DrawY<480, evaluated combinationally each cycle.
REQ-020 In a read-window cycle the block SHALL drive ram_addr={DrawY[8:1],DrawX[8:1]} and ram_we=0, so reads have absolute priority.
REQ-021 Outside the read window, when the FIFO is non-empty, the block SHALL pop the head entry and drive ram_addr/ram_wdata from it with ram_we=1 in that same cycle.
REQ-022 Outside the read window with the FIFO empty, the block SHALL drive ram_we=0 and hold ram_addr at its last value.
REQ-023 The block SHALL never write to the RAM in a read-window cycle, and it SHALL never pop the FIFO in such a cycle.
REQ-024 The FIFO SHALL be FIFO_DEPTH entries of {addr,data} with wr_ready = !full, registered from the occupancy count.
REQ-025 A push SHALL occur when wr_valid=1 and wr_ready=1.
REQ-026 When full, a simultaneous pop SHALL NOT enable a push in the same cycle, because wr_ready is already 0.
REQ-027 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 The occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH or go below 0.
REQ-030 fifo_overrun SHALL set when wr_valid=1 and wr_ready=0, and SHALL clear only on Reset.
REQ-031 Read pipeline: a read issued in cycle N SHALL produce pix_data = ram_rdata registered at the end of cycle N+1, so pix_data is visible in cycle N+2.
REQ-032 A 2-stage window-valid shift register SHALL track each read.
REQ-033 When the delayed window bit is 0, pix_data SHALL equal BORDER_COLOR.
REQ-034 The frame FSM SHALL have states ACTIVE (DrawY<480) and VBLANK (DrawY>=480).
REQ-035 The ACTIVE->VBLANK transition SHALL assert vblank_pulse for exactly one cycle.
REQ-036 The VBLANK->ACTIVE transition SHALL occur when DrawY returns below 480, with no pulse.
REQ-037 No RAM reads SHALL occur in VBLANK, so the FIFO drains at one entry per cycle.

Reset
REQ-038 While Reset=1, the block SHALL empty the FIFO and discard all entries.
REQ-039 While Reset=1, the block SHALL drive wr_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, pix_data=BORDER_COLOR, vblank_pulse=0, fifo_overrun=0, pipeline valid bits=0, and FSM=ACTIVE.
REQ-040 In the first cycle after Reset deasserts, wr_ready SHALL be 1.
REQ-041 A reset asserted mid-frame or mid-drain SHALL abort without completing the pending RAM write of that cycle.

Verification
REQ-042 The bench SHALL cover: blank=1, DrawX=20, DrawY=10 -> ram_addr=16'h050A, ram_we=0; with ram_rdata=6'h21 one cycle later -> pix_data=6'h21 two cycles after the address cycle.
REQ-043 The bench SHALL cover: a push of {16'h1234,6'h05} during the read window -> no ram_we while the window persists; on the first cycle with blank=0 -> ram_we=1, ram_addr=16'h1234, ram_wdata=6'h05.
REQ-044 The bench SHALL cover: 16 pushes during the read window -> wr_ready=0 after the 16th; a 17th wr_valid -> fifo_overrun=1 and it stays 1; then blank=0 -> 16 consecutive ram_we cycles in push order, after which wr_ready=1.
REQ-045 The bench SHALL cover: DrawY stepping 479->480 -> vblank_pulse=1 for one cycle only; DrawY 524->0 -> no pulse.
REQ-046 The bench SHALL cover: DrawX=600 with blank=1 -> pix_data=6'h0F two cycles later and a queued write proceeds in the address cycle.
REQ-047 The bench SHALL cover: Reset asserted with 5 entries queued -> the next cycle shows ram_we=0 and the FIFO empty, and no queued write ever reaches the RAM.
